// File: rtl/riscboy_ppu_mem_responder.sv
// PPU read port: halfword reads from a 32-bit SRAM, fixed READ_LATENCY+1 cycle response, strictly in order.
// No response back-pressure; misses wait for sram_gnt, same-word hits bypass SRAM via a one-word reuse buffer.
module riscboy_ppu_mem_responder #(
    parameter int W_ADDR       = 18,
    parameter int W_DATA       = 16,
    parameter int READ_LATENCY = 2,
    parameter int ENABLE_REUSE = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [W_ADDR-1:0]     i_mem_addr,
    input  logic                  i_mem_addr_vld,
    output logic                  o_mem_addr_rdy,
    output logic [W_DATA-1:0]     o_mem_rdata,
    output logic                  o_mem_rdata_vld,
    output logic [W_ADDR-2:0]     o_sram_addr,
    output logic                  o_sram_req,
    input  logic                  i_sram_gnt,
    input  logic [2*W_DATA-1:0]   i_sram_rdata,
    input  logic                  i_reuse_inval,
    output logic                  o_busy
);

    localparam int W_WADDR = W_ADDR - 1;
    localparam int W_WORD  = 2 * W_DATA;

    logic [W_WADDR-1:0]      w_word_addr;
    logic                    w_hit;
    logic                    w_accept;
    logic                    w_accept_miss;
    logic [W_WORD-1:0]       w_word_buf;

    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [READ_LATENCY-1:0] r_pipe_hit;
    logic [READ_LATENCY-1:0] r_pipe_hsel;

    logic                    w_exit_vld;
    logic                    w_exit_hit;
    logic                    w_exit_hsel;
    logic [W_WORD-1:0]       w_exit_word;
    logic [W_DATA-1:0]       w_exit_half;

    logic [W_DATA-1:0]       r_rdata;
    logic                    r_rdata_vld;

    assign w_word_addr   = i_mem_addr[W_ADDR-1:1];
    assign w_accept      = i_mem_addr_vld && o_mem_addr_rdy;
    assign w_accept_miss = w_accept && !w_hit;

    assign o_sram_req     = i_mem_addr_vld && !w_hit;
    assign o_sram_addr    = w_word_addr;
    assign o_mem_addr_rdy = w_hit || i_sram_gnt;

    assign w_exit_vld  = r_pipe_vld[READ_LATENCY-1];
    assign w_exit_hit  = r_pipe_hit[READ_LATENCY-1];
    assign w_exit_hsel = r_pipe_hsel[READ_LATENCY-1];

    generate
        if (ENABLE_REUSE != 0) begin : g_reuse
            logic [W_WADDR-1:0] r_tag;
            logic               r_tag_vld;
            logic [W_WORD-1:0]  r_word_buf;

            // Tag is claimed at issue so back-to-back same-word reads hit before the data returns.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_tag      <= '0;
                    r_tag_vld  <= 1'b0;
                    r_word_buf <= '0;
                end else begin
                    if (w_accept_miss) begin
                        r_tag     <= w_word_addr;
                        r_tag_vld <= 1'b1;
                    end else if (i_reuse_inval) begin
                        r_tag_vld <= 1'b0;
                    end
                    if (w_exit_vld && !w_exit_hit) begin
                        r_word_buf <= i_sram_rdata;
                    end
                end
            end

            assign w_hit      = r_tag_vld && (r_tag == w_word_addr) && !i_reuse_inval;
            assign w_word_buf = r_word_buf;
        end else begin : g_no_reuse
            assign w_hit      = 1'b0;
            assign w_word_buf = '0;
        end
    endgenerate

    // Last stage lines up with the cycle sram_rdata is valid for the oldest miss.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pipe_vld  <= '0;
            r_pipe_hit  <= '0;
            r_pipe_hsel <= '0;
        end else begin
            r_pipe_vld[0]  <= w_accept;
            r_pipe_hit[0]  <= w_hit;
            r_pipe_hsel[0] <= i_mem_addr[0];
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_pipe_vld[k]  <= r_pipe_vld[k-1];
                r_pipe_hit[k]  <= r_pipe_hit[k-1];
                r_pipe_hsel[k] <= r_pipe_hsel[k-1];
            end
        end
    end

    assign w_exit_word = w_exit_hit ? w_word_buf : i_sram_rdata;
    assign w_exit_half = w_exit_hsel ? w_exit_word[W_WORD-1:W_DATA] : w_exit_word[W_DATA-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata     <= '0;
            r_rdata_vld <= 1'b0;
        end else begin
            r_rdata_vld <= w_exit_vld;
            if (w_exit_vld) begin
                r_rdata <= w_exit_half;
            end
        end
    end

    assign o_mem_rdata     = r_rdata;
    assign o_mem_rdata_vld = r_rdata_vld;
    assign o_busy          = (|r_pipe_vld) || r_rdata_vld;

endmodule

// File: doc/riscboy_ppu_mem_responder.md
# riscboy_ppu_mem_responder

Responder for the PPU's read-only memory port: it accepts halfword read addresses from the PPU bus arbiter, fetches 32-bit words from the shared SRAM port, and returns 16-bit read data in order at a fixed latency. A one-word reuse buffer serves consecutive reads to the same word without an SRAM access. It sits between the PPU and the system SRAM arbiter, where the processor can withhold the grant.

## Interface
Parameters:
- W_ADDR, 18, halfword address width on the PPU side.
- W_DATA, 16, PPU data width; the SRAM word is 2*W_DATA.
- READ_LATENCY, 2, cycles from an accepted SRAM request to valid sram_rdata; must be ≥1.
- ENABLE_REUSE, 1, enables the word reuse buffer. 0 means every request is a miss.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  reset; **one clock; reset is synchronous and active-high**.
- mem_addr  in  W_ADDR  halfword read address.
- mem_addr_vld  in  1  request valid.
- mem_addr_rdy  out  1  request accepted when mem_addr_vld && mem_addr_rdy.
- mem_rdata  out  W_DATA  read data.
- mem_rdata_vld  out  1  one-cycle data strobe; there is no back-pressure.
- sram_addr  out  W_ADDR-1  word address, equal to mem_addr[W_ADDR-1:1].
- sram_req  out  1  SRAM read request.
- sram_gnt  in  1  SRAM port available this cycle.
- sram_rdata  in  2*W_DATA  word data, valid READ_LATENCY cycles after sram_req && sram_gnt.
- reuse_inval  in  1  clears the reuse tag. Asserted when another master writes the SRAM.
- busy  out  1  at least one response is in flight.

## Operation
- Hit definition: hit = ENABLE_REUSE && tag_vld && (tag == mem_addr[W_ADDR-1:1]) && !reuse_inval.
- Miss requests:
  - sram_req = mem_addr_vld && !hit.
  - sram_addr = mem_addr[W_ADDR-1:1]. Both are combinational.
- Acceptance:
  - mem_addr_rdy = hit || sram_gnt.
  - A hit is accepted even while sram_gnt is low.
- Tag update on an accepted miss: tag <= word address and tag_vld <= 1.
  - This happens at issue, not at return.
- reuse_inval clears tag_vld next cycle.
  - If reuse_inval and an accepted miss occur in the same cycle, the miss wins: tag_vld = 1 with the new tag.
- Response pipeline:
  - READ_LATENCY+1 stages, each holding {vld, hit, hsel}, where hsel = mem_addr[0].
  - The pipeline advances every cycle and never stalls.
- At stage READ_LATENCY (the cycle sram_rdata is valid), a miss entry:
  - loads word_buf <= sram_rdata;
  - loads the output register from sram_rdata.
- A hit entry loads the output register from word_buf.
  - Ordering guarantees the matching miss has already loaded word_buf one or more cycles earlier.
- Halfword select: hsel=0 selects bits [W_DATA-1:0]; hsel=1 selects [2*W_DATA-1:W_DATA].
- Output register: mem_rdata updates only when a valid entry exits; otherwise it holds its value.
- busy = OR of all pipeline vld bits.

## Timing
- Request accepted in cycle T produces mem_rdata_vld=1 in cycle T+READ_LATENCY+1, for both hits and misses.
- Responses are strictly in acceptance order. One request can be accepted per cycle, giving one response per cycle.
- Reset values:
  - mem_rdata=0, mem_rdata_vld=0, busy=0.
  - tag_vld=0, tag=0, word_buf=0.
  - All pipeline vld bits 0.
  - sram_req and mem_addr_rdy follow their combinational equations from the reset state.
- Reset mid-operation drops all in-flight responses: no mem_rdata_vld after rst.
  - Late SRAM data arriving after reset is ignored.
- sram_gnt low with a miss pending: mem_addr_rdy=0 and sram_req stays asserted. The tag does not change.
- ENABLE_REUSE=0: word_buf and tag logic are removed, and mem_addr_rdy = sram_gnt.

## Test plan
- Single miss, READ_LATENCY=2: addr 0x00011, accepted at T; sram_rdata=0xBEEF_1234 at T+2. Required: mem_rdata=0xBEEF, mem_rdata_vld=1 at T+3 only; busy=1 for T+1..T+3.
- Back-to-back same word: addrs 0x20, 0x21, 0x20 on consecutive cycles, gnt=1. Required: one sram_req cycle; responses low, high, low halves at T+3, T+4, T+5.
- Grant stall: miss 0x40 with sram_gnt=0 for 3 cycles, then 1. Required: mem_addr_rdy=0 for 3 cycles, accepted on cycle 4. A hit to the current tag is accepted while gnt=0.
- Invalidate: hit-pattern address presented with reuse_inval=1. Required: treated as a miss (sram_req=1) and returns the new SRAM data, not word_buf.
- Alternating words 0x10, 0x30, 0x11, 0x31 every cycle. Required: 4 SRAM requests and 4 in-order responses with correct halves.
- Reset mid-flight: accept 2 misses, assert rst at T+1. Required: no mem_rdata_vld afterwards; busy=0 and tag_vld=0 after reset.
